shared_gf2n_mul_dom_pipe: RTL and testbench

- Parametrised d-share DOM-indep masked multiplier over GF(2^N).
- Successor to the fixed 2-bit shared square-scale multiplier; generalised in share count, field width and pipeline depth.
- Adds a runtime mode select (plain multiply / multiply plus square-scale) and a valid/ready handshake with backpressure.
- Sits inside the masked AES S-box datapath between the GF(2^4) inversion stages; consumes fresh randomness only on accepted transfers.

---
 rtl/shared_gf2n_mul_dom_pipe.sv | 247 ++++++++++++++++++++++++
 tb/tb_shared_gf2n_mul_dom_pipe.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shared_gf2n_mul_dom_pipe.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : shared_gf2n_mul_dom_pipe
// Description : d-share DOM-indep masked multiplier over GF(2^N) with an
//               optional square-scale term, valid/ready handshake and an
//               optional registered output compression stage.
//               Field polynomials: N=2 -> x^2+x+1, N=4 -> x^4+x+1
//               (polynomial basis). Square-scale: sqsc(a) = x * a^2 (N=2).
// Revision    : 1.0 - initial release
// ============================================================================
module shared_gf2n_mul_dom_pipe #(
    parameter int SHARES = 2,
    parameter int N      = 2,
    parameter int OUTREG = 1,
    parameter int RANDW  = N*SHARES*(SHARES-1)/2
) (
    input  logic                ClkxCI,
    input  logic                RstxRI,
    input  logic                InValidxSI,
    output logic                InReadyxSO,
    input  logic                ModexSI,
    input  logic [N*SHARES-1:0] XxDI,
    input  logic [N*SHARES-1:0] YxDI,
    input  logic [RANDW-1:0]    ZxDI,
    output logic                OutValidxSO,
    input  logic                OutReadyxSI,
    output logic [N*SHARES-1:0] QxDO
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int          c_NPAIRS  = SHARES*(SHARES-1)/2;
    localparam int          c_W       = N*SHARES;
    // Reduction term: both x^2+x+1 and x^4+x+1 fold the top bit back as x+1.
    localparam logic [N-1:0] c_RED    = N'(3);
    // Square-scale multiplier constant (the element x).
    localparam logic [N-1:0] c_SCALE  = N'(2);
    // The square-scale mode only exists for the 2-bit field.
    localparam bit          c_MODE_OK = (N == 2);

    // ------------------------------------------------------------------------
    // Configuration guards: refuse to elaborate unsupported shapes.
    // ------------------------------------------------------------------------
    if ((N != 2) && (N != 4)) begin : g_bad_n
        $error("shared_gf2n_mul_dom_pipe: N must be 2 or 4");
    end
    if (SHARES < 2) begin : g_bad_shares
        $error("shared_gf2n_mul_dom_pipe: SHARES must be at least 2");
    end
    if (RANDW != N*SHARES*(SHARES-1)/2) begin : g_bad_randw
        $error("shared_gf2n_mul_dom_pipe: RANDW must equal N*SHARES*(SHARES-1)/2");
    end

    // ------------------------------------------------------------------------
    // Field arithmetic
    // ------------------------------------------------------------------------
    function automatic logic [N-1:0] gf_xtime(input logic [N-1:0] a);
        return {a[N-2:0], 1'b0} ^ (a[N-1] ? c_RED : '0);
    endfunction

    // Shift-and-add multiply; one partial product per bit of b.
    function automatic logic [N-1:0] gf_mul(input logic [N-1:0] a,
                                            input logic [N-1:0] b);
        logic [N-1:0] acc;
        logic [N-1:0] sh;
        acc = '0;
        sh  = a;
        for (int i = 0; i < N; i++) begin
            if (b[i]) begin
                acc = acc ^ sh;
            end
            sh = gf_xtime(sh);
        end
        return acc;
    endfunction

    // Linear in a, so it can be applied share-wise without combining domains.
    function automatic logic [N-1:0] gf_sqsc(input logic [N-1:0] a);
        return gf_mul(gf_mul(a, a), c_SCALE);
    endfunction

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    logic [N-1:0] w_x [SHARES];
    logic [N-1:0] w_y [SHARES];
    logic [N-1:0] w_z [c_NPAIRS];
    logic         w_mode_in;

    logic         w_down_load;   // successor of stage 1 takes data this cycle
    logic         w_s1_load;     // stage 1 may capture a new transfer
    logic         w_accept;

    logic [N-1:0] r_inner_q [SHARES];
    logic [N-1:0] w_inner_d [SHARES];
    logic [N-1:0] r_sqsc_q  [SHARES];
    logic [N-1:0] w_sqsc_d  [SHARES];
    logic [N-1:0] r_cij_q   [c_NPAIRS];
    logic [N-1:0] w_cij_d   [c_NPAIRS];
    logic [N-1:0] r_cji_q   [c_NPAIRS];
    logic [N-1:0] w_cji_d   [c_NPAIRS];
    logic         r_mode_q;
    logic         w_mode_d;
    logic         r_s1_valid_q;
    logic         w_s1_valid_d;

    logic [N-1:0] w_comp [SHARES];
    logic [c_W-1:0] w_comp_flat;

    // ------------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------------
    assign w_s1_load  = ~r_s1_valid_q | w_down_load;
    assign InReadyxSO = w_s1_load;
    assign w_accept   = InValidxSI & w_s1_load;
    assign w_mode_in  = ModexSI & c_MODE_OK;

    // Split the packed share buses into per-share / per-pair words.
    always_comb begin : p_unpack
        for (int i = 0; i < SHARES; i++) begin
            w_x[i] = XxDI[i*N +: N];
            w_y[i] = YxDI[i*N +: N];
        end
        for (int k = 0; k < c_NPAIRS; k++) begin
            w_z[k] = ZxDI[k*N +: N];
        end
    end

    // Stage 1 next state: DOM products captured only on an accepted transfer,
    // otherwise every register (masks included) keeps its own value.
    always_comb begin : p_s1_next
        int k;
        k            = 0;
        w_inner_d    = r_inner_q;
        w_sqsc_d     = r_sqsc_q;
        w_cij_d      = r_cij_q;
        w_cji_d      = r_cji_q;
        w_mode_d     = r_mode_q;
        w_s1_valid_d = w_s1_load ? w_accept : r_s1_valid_q;
        if (w_accept) begin
            for (int i = 0; i < SHARES; i++) begin
                w_inner_d[i] = gf_mul(w_x[i], w_y[i]);
                w_sqsc_d[i]  = gf_sqsc(w_x[i] ^ w_y[i]);
            end
            // Pairs (i<j) enumerated lexicographically, matching ZxDI order.
            for (int i = 0; i < SHARES; i++) begin
                for (int j = i + 1; j < SHARES; j++) begin
                    w_cij_d[k] = gf_mul(w_x[i], w_y[j]) ^ w_z[k];
                    w_cji_d[k] = gf_mul(w_x[j], w_y[i]) ^ w_z[k];
                    k = k + 1;
                end
            end
            w_mode_d = w_mode_in;
        end
    end

    // Stage 1 registers: the DOM boundary for every cross-domain product.
    always_ff @(posedge ClkxCI or posedge RstxRI) begin : p_s1_regs
        if (RstxRI) begin
            r_s1_valid_q <= 1'b0;
            r_mode_q     <= 1'b0;
            for (int i = 0; i < SHARES; i++) begin
                r_inner_q[i] <= '0;
                r_sqsc_q[i]  <= '0;
            end
            for (int k = 0; k < c_NPAIRS; k++) begin
                r_cij_q[k] <= '0;
                r_cji_q[k] <= '0;
            end
        end else begin
            r_s1_valid_q <= w_s1_valid_d;
            r_mode_q     <= w_mode_d;
            r_inner_q    <= w_inner_d;
            r_sqsc_q     <= w_sqsc_d;
            r_cij_q      <= w_cij_d;
            r_cji_q      <= w_cji_d;
        end
    end

    // Compression: each output share folds its own inner term with the
    // already-masked, already-registered cross terms addressed to it.
    always_comb begin : p_compress
        int k;
        k           = 0;
        w_comp_flat = '0;
        for (int i = 0; i < SHARES; i++) begin
            w_comp[i] = r_inner_q[i] ^ (r_mode_q ? r_sqsc_q[i] : '0);
        end
        for (int i = 0; i < SHARES; i++) begin
            for (int j = i + 1; j < SHARES; j++) begin
                w_comp[i] = w_comp[i] ^ r_cij_q[k];
                w_comp[j] = w_comp[j] ^ r_cji_q[k];
                k = k + 1;
            end
        end
        for (int i = 0; i < SHARES; i++) begin
            w_comp_flat[i*N +: N] = w_comp[i];
        end
    end

    // ------------------------------------------------------------------------
    // Output stage
    // ------------------------------------------------------------------------
    if (OUTREG != 0) begin : g_outreg
        logic           r_s2_valid_q;
        logic           w_s2_valid_d;
        logic [c_W-1:0] r_q_q;
        logic [c_W-1:0] w_q_d;
        logic           w_s2_load;

        assign w_s2_load   = ~r_s2_valid_q | OutReadyxSI;
        assign w_down_load = w_s2_load;
        assign OutValidxSO = r_s2_valid_q;
        assign QxDO        = r_q_q;

        // Stage 2 next state: take stage 1 when free or draining, else hold.
        always_comb begin : p_s2_next
            w_s2_valid_d = r_s2_valid_q;
            w_q_d        = r_q_q;
            if (w_s2_load) begin
                w_s2_valid_d = r_s1_valid_q;
                if (r_s1_valid_q) begin
                    w_q_d = w_comp_flat;
                end
            end
        end

        // Stage 2 registers: registered compressed output shares.
        always_ff @(posedge ClkxCI or posedge RstxRI) begin : p_s2_regs
            if (RstxRI) begin
                r_s2_valid_q <= 1'b0;
                r_q_q        <= '0;
            end else begin
                r_s2_valid_q <= w_s2_valid_d;
                r_q_q        <= w_q_d;
            end
        end
    end else begin : g_outcomb
        assign w_down_load = OutReadyxSI;
        assign OutValidxSO = r_s1_valid_q;
        assign QxDO        = w_comp_flat;
    end

endmodule
`default_nettype wire

// File: tb/tb_shared_gf2n_mul_dom_pipe.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_shared_gf2n_mul_dom_pipe
// Description : Scoreboard bench for two configurations of the masked
//               GF(2^N) multiplier (2 shares/N=2/registered output and
//               3 shares/N=4/combinational output). Expected values come
//               from log/antilog tables of the field, not gate equations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shared_gf2n_mul_dom_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Configuration A: SHARES=2, N=2, OUTREG=1
    logic       a_in_valid, a_in_ready, a_mode, a_out_valid, a_out_ready;
    logic [3:0] a_x, a_y, a_q;
    logic [1:0] a_z;
    // Configuration B: SHARES=3, N=4, OUTREG=0
    logic        b_in_valid, b_in_ready, b_mode, b_out_valid, b_out_ready;
    logic [11:0] b_x, b_y, b_z, b_q;

    shared_gf2n_mul_dom_pipe #(.SHARES(2), .N(2), .OUTREG(1)) u_dut_a (
        .ClkxCI(clk), .RstxRI(rst),
        .InValidxSI(a_in_valid), .InReadyxSO(a_in_ready), .ModexSI(a_mode),
        .XxDI(a_x), .YxDI(a_y), .ZxDI(a_z),
        .OutValidxSO(a_out_valid), .OutReadyxSI(a_out_ready), .QxDO(a_q)
    );

    shared_gf2n_mul_dom_pipe #(.SHARES(3), .N(4), .OUTREG(0)) u_dut_b (
        .ClkxCI(clk), .RstxRI(rst),
        .InValidxSI(b_in_valid), .InReadyxSO(b_in_ready), .ModexSI(b_mode),
        .XxDI(b_x), .YxDI(b_y), .ZxDI(b_z),
        .OutValidxSO(b_out_valid), .OutReadyxSI(b_out_ready), .QxDO(b_q)
    );

    typedef struct {
        int  q;        // expected unmasked result
        bit  sh_chk;   // compare individual shares too
        int  sh;       // expected packed shares
        int  acc_cyc;  // cycle count right after the accepting edge
        int  lat;      // expected latency, 0 = not checked
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;
    int   checks   = 0;
    int   failures = 0;
    int   a_lat_exp = 0;
    int   b_lat_exp = 0;

    // ---------------- reference model (log / antilog tables) ----------------
    int exp2t[3], log2t[4], exp4t[15], log4t[16];

    task automatic build_tables();
        int e;
        e = 1;
        for (int i = 0; i < 3; i++) begin
            exp2t[i] = e; log2t[e] = i;
            e = e << 1; if ((e & 4) != 0) e = e ^ 7;
        end
        e = 1;
        for (int i = 0; i < 15; i++) begin
            exp4t[i] = e; log4t[e] = i;
            e = e << 1; if ((e & 16) != 0) e = e ^ 19;
        end
    endtask

    function automatic int gmul(int n, int a, int b);
        if (a == 0 || b == 0) return 0;
        if (n == 2) return exp2t[(log2t[a] + log2t[b]) % 3];
        return exp4t[(log4t[a] + log4t[b]) % 15];
    endfunction

    // x * a^2 in GF(4)
    function automatic int sqsc2(int a);
        if (a == 0) return 0;
        return exp2t[(2*log2t[a] + 1) % 3];
    endfunction

    function automatic int unmask(logic [15:0] v, int n, int s);
        int r;
        r = 0;
        for (int i = 0; i < s; i++) r = r ^ int'((v >> (i*n)) & ((16'd1 << n) - 16'd1));
        return r;
    endfunction

    function automatic int ref_q(int n, int s, logic [15:0] x, logic [15:0] y, bit mode);
        int xu, yu, r;
        xu = unmask(x, n, s);
        yu = unmask(y, n, s);
        r  = gmul(n, xu, yu);
        if (mode && n == 2) r = r ^ sqsc2(xu ^ yu);
        return r;
    endfunction

    // Two-share outputs: Q0 = x0y0 ^ s0 ^ x0y1 ^ z, Q1 = x1y1 ^ s1 ^ x1y0 ^ z
    function automatic int ref_shares_a(logic [3:0] x, logic [3:0] y, logic [1:0] z, bit mode);
        int x0, x1, y0, y1, q0, q1;
        x0 = int'(x[1:0]); x1 = int'(x[3:2]);
        y0 = int'(y[1:0]); y1 = int'(y[3:2]);
        q0 = gmul(2, x0, y0) ^ gmul(2, x0, y1) ^ int'(z);
        q1 = gmul(2, x1, y1) ^ gmul(2, x1, y0) ^ int'(z);
        if (mode) begin
            q0 = q0 ^ sqsc2(x0 ^ y0);
            q1 = q1 ^ sqsc2(x1 ^ y1);
        end
        return (q1 << 2) | q0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // ---------------- stimulus steps: push expectation on acceptance --------
    task automatic step_a(output bit acc);
        exp_t e;
        #1;
        acc = a_in_valid && a_in_ready;
        if (acc) begin
            e.q = ref_q(2, 2, 16'(a_x), 16'(a_y), a_mode);
            e.sh_chk = 1'b1;
            e.sh = ref_shares_a(a_x, a_y, a_z, a_mode);
            e.acc_cyc = cyc + 1;
            e.lat = a_lat_exp;
            qa.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic step_b(output bit acc);
        exp_t e;
        #1;
        acc = b_in_valid && b_in_ready;
        if (acc) begin
            e.q = ref_q(4, 3, 16'(b_x), 16'(b_y), b_mode);
            e.sh_chk = 1'b0;
            e.sh = 0;
            e.acc_cyc = cyc + 1;
            e.lat = b_lat_exp;
            qb.push_back(e);
        end
        @(negedge clk);
    endtask

    // ---------------- monitors: pop and compare on every handoff ------------
    always @(negedge clk) begin
        #2;
        if (!rst && a_out_valid && a_out_ready) begin
            if (qa.size() == 0) begin
                checks++; failures++;
                $display("FAIL a_unexpected_output actual=%0h required=no output", a_q);
            end else begin
                ea = qa.pop_front();
                check("a_q_unmasked", 32'(unmask(16'(a_q), 2, 2)), 32'(ea.q));
                if (ea.sh_chk) check("a_q_shares", 32'(a_q), 32'(ea.sh));
                if (ea.lat != 0) check("a_latency", 32'(cyc - ea.acc_cyc + 1), 32'(ea.lat));
            end
        end
    end

    always @(negedge clk) begin
        #2;
        if (!rst && b_out_valid && b_out_ready) begin
            if (qb.size() == 0) begin
                checks++; failures++;
                $display("FAIL b_unexpected_output actual=%0h required=no output", b_q);
            end else begin
                eb = qb.pop_front();
                check("b_q_unmasked", 32'(unmask(16'(b_q), 4, 3)), 32'(eb.q));
                if (eb.lat != 0) check("b_latency", 32'(cyc - eb.acc_cyc + 1), 32'(eb.lat));
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        bit         acc;
        int         nacc;
        logic [3:0] snap;
        build_tables();
        a_in_valid = 0; a_mode = 0; a_out_ready = 0; a_x = 0; a_y = 0; a_z = 0;
        b_in_valid = 0; b_mode = 0; b_out_ready = 0; b_x = 0; b_y = 0; b_z = 0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("a_rst_out_valid", 32'(a_out_valid), 0);
        check("a_rst_q", 32'(a_q), 0);
        check("a_rst_in_ready", 32'(a_in_ready), 1);
        check("b_rst_out_valid", 32'(b_out_valid), 0);
        check("b_rst_q", 32'(b_q), 0);
        check("b_rst_in_ready", 32'(b_in_ready), 1);
        @(negedge clk);

        // A: single transfer, mode 0, Z=0, latency 2
        a_out_ready = 1; a_in_valid = 1; a_mode = 0;
        a_x = 4'b0001; a_y = 4'b0010; a_z = 2'b00; a_lat_exp = 2;
        step_a(acc);
        check("a_first_accept", 32'(acc), 1);
        a_in_valid = 0; a_lat_exp = 0;
        repeat (3) step_a(acc);

        // A: same operands, mode 1, fresh Z each transfer
        a_mode = 1; a_in_valid = 1;
        for (int i = 0; i < 20; i++) begin
            a_z = 2'($urandom);
            step_a(acc);
        end

        // A: random traffic with random backpressure
        for (int i = 0; i < 1000; i++) begin
            a_in_valid  = ($urandom_range(0, 3) != 0);
            a_out_ready = ($urandom_range(0, 3) != 0);
            a_x = 4'($urandom); a_y = 4'($urandom); a_z = 2'($urandom);
            a_mode = 1'($urandom);
            step_a(acc);
        end
        a_in_valid = 0; a_out_ready = 1;
        repeat (4) step_a(acc);

        // A: X all zero with Z=11 -> both shares equal 11
        a_in_valid = 1; a_mode = 0; a_x = 4'b0000; a_z = 2'b11;
        for (int i = 0; i < 5; i++) begin
            a_y = 4'($urandom);
            step_a(acc);
        end
        a_in_valid = 0;
        repeat (4) step_a(acc);

        // A: fill the pipe under backpressure, then vary inputs during stall
        a_out_ready = 0; a_in_valid = 1; nacc = 0;
        for (int i = 0; i < 4; i++) begin
            a_x = 4'($urandom); a_y = 4'($urandom); a_z = 2'($urandom); a_mode = 1'($urandom);
            step_a(acc);
            nacc = nacc + int'(acc);
        end
        check("a_stall_accepts", 32'(nacc), 2);
        check("a_stall_in_ready", 32'(a_in_ready), 0);
        check("a_stall_out_valid", 32'(a_out_valid), 1);
        snap = a_q;
        for (int i = 0; i < 5; i++) begin
            a_x = 4'($urandom); a_y = 4'($urandom); a_z = 2'($urandom);
            step_a(acc);
            check("a_stall_no_accept", 32'(acc), 0);
            check("a_stall_q_stable", 32'(a_q), 32'(snap));
        end
        a_in_valid = 0; a_out_ready = 1;
        repeat (4) step_a(acc);

        // A: reset with two items in flight
        a_out_ready = 0; a_in_valid = 1; nacc = 0;
        for (int i = 0; i < 2; i++) begin
            a_x = 4'($urandom); a_y = 4'($urandom); a_z = 2'($urandom);
            step_a(acc);
            nacc = nacc + int'(acc);
        end
        check("a_inflight_accepts", 32'(nacc), 2);
        a_in_valid = 0;
        #3 rst = 1'b1;
        #1;
        check("a_midrst_out_valid", 32'(a_out_valid), 0);
        check("a_midrst_q", 32'(a_q), 0);
        qa.delete();
        qb.delete();
        @(negedge clk);
        rst = 1'b0;
        a_out_ready = 1;
        for (int i = 0; i < 3; i++) begin
            step_a(acc);
            check("a_post_rst_idle", 32'(a_out_valid), 0);
        end
        a_in_valid = 1; a_mode = 0; a_x = 4'b0110; a_y = 4'b1011; a_z = 2'b01; a_lat_exp = 2;
        step_a(acc);
        check("a_post_rst_accept", 32'(acc), 1);
        a_in_valid = 0; a_lat_exp = 0;
        repeat (4) step_a(acc);

        // B: 16 back-to-back transfers, latency 1 each
        b_out_ready = 1; b_in_valid = 1; b_mode = 0; b_lat_exp = 1;
        for (int i = 0; i < 16; i++) begin
            b_x = 12'($urandom); b_y = 12'($urandom); b_z = 12'($urandom);
            step_b(acc);
            check("b_burst_accept", 32'(acc), 1);
        end
        b_in_valid = 0; b_lat_exp = 0;
        repeat (3) step_b(acc);

        // B: random traffic, random mode (mode 1 behaves as mode 0 for N=4)
        for (int i = 0; i < 400; i++) begin
            b_in_valid  = ($urandom_range(0, 3) != 0);
            b_out_ready = ($urandom_range(0, 2) != 0);
            b_x = 12'($urandom); b_y = 12'($urandom); b_z = 12'($urandom);
            b_mode = 1'($urandom);
            step_b(acc);
        end

        // B: X all zero
        b_mode = 0; b_x = 12'h000; b_in_valid = 1;
        for (int i = 0; i < 8; i++) begin
            b_out_ready = 1'($urandom);
            b_y = 12'($urandom); b_z = 12'($urandom);
            step_b(acc);
        end

        // Drain both scoreboards within a bounded number of cycles
        b_in_valid = 0; b_out_ready = 1; a_in_valid = 0; a_out_ready = 1;
        for (int i = 0; i < 20; i++) begin
            if (qa.size() == 0 && qb.size() == 0) break;
            @(negedge clk);
        end
        repeat (2) @(negedge clk);
        check("a_drain_empty", 32'(qa.size()), 0);
        check("b_drain_empty", 32'(qb.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
